// File: rtl/conv_seq_fsm_pkg.sv
// Shared types and datapath defaults for the convolution sequencer.
// Address/latency defaults must agree with the Conv lanes and MCU buffer.
package conv_seq_fsm_pkg;

  localparam int NB_ADDRESS_D = 10;
  localparam int M_LEN_D      = 3;
  localparam int CONV_LAT_D   = 3;
  localparam int NB_BLK_D     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KLOAD = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

endpackage

// File: rtl/conv_seq_fsm_if.sv
// Micro-side commands and datapath strobes of the conv sequencer.
// master = command/consumer side, slave = the sequencer.
interface conv_seq_fsm_if
  import conv_seq_fsm_pkg::*;
#(
  parameter int NB_ADDRESS = NB_ADDRESS_D,
  parameter int NB_BLK     = NB_BLK_D
);

  logic                  i_start;
  logic                  i_next;
  logic [NB_ADDRESS-1:0] i_last_addr;
  logic [NB_BLK-1:0]     i_nblk;
  logic [NB_ADDRESS-1:0] o_RAddr;
  logic [NB_ADDRESS-1:0] o_WAddr;
  logic                  o_valid;
  logic                  o_ki;
  logic                  o_sop;
  logic                  o_eop;
  logic                  o_chblk;
  logic [NB_BLK-1:0]     o_blk;
  logic                  o_done;

  modport master (
    output i_start, i_next, i_last_addr, i_nblk,
    input  o_RAddr, o_WAddr, o_valid, o_ki, o_sop,
    input  o_eop, o_chblk, o_blk, o_done
  );

  modport slave (
    input  i_start, i_next, i_last_addr, i_nblk,
    output o_RAddr, o_WAddr, o_valid, o_ki, o_sop,
    output o_eop, o_chblk, o_blk, o_done
  );

endinterface

// File: rtl/conv_seq_fsm_edge_det.sv
// Rising-edge detector for a GPIO level; one register of history.
module conv_seq_fsm_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= in_i;
  end

  assign edge_o = in_i & ~prev_q;

endmodule

// File: rtl/conv_seq_fsm.sv
// Frame sequencer: kernel load, per-block image sweep with write-back
// trailing the read address by the Conv pipeline latency.
module conv_seq_fsm
  import conv_seq_fsm_pkg::*;
#(
  parameter int NB_ADDRESS = NB_ADDRESS_D,
  parameter int M_LEN      = M_LEN_D,
  parameter int CONV_LAT   = CONV_LAT_D,
  parameter int NB_BLK     = NB_BLK_D
) (
  input logic           CLK100MHZ,
  input logic           i_reset,
  conv_seq_fsm_if.slave bus
);

  localparam int CW = $clog2(CONV_LAT + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(CONV_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [NB_ADDRESS-1:0] A_ONE = NB_ADDRESS'(1);
  localparam logic [NB_ADDRESS-1:0] KL_LAST = NB_ADDRESS'(M_LEN - 1);
  localparam logic [NB_BLK-1:0] B_ONE = NB_BLK'(1);

  state_e                state_q, state_d;
  logic [NB_ADDRESS-1:0] raddr_q, raddr_d;
  logic [NB_ADDRESS-1:0] waddr_q, waddr_d;
  logic [NB_ADDRESS-1:0] last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NB_BLK-1:0]     blk_q, blk_d;
  logic [NB_BLK-1:0]     nblk_q, nblk_d;
  logic valid_q, valid_d, ki_q, ki_d;
  logic sop_q, sop_d, eop_q, eop_d;
  logic chblk_q, chblk_d, done_q, done_d;
  logic start_edge, next_edge;

  conv_seq_fsm_edge_det u_start (
    .clk_i  (CLK100MHZ),
    .rst_i  (i_reset),
    .in_i   (bus.i_start),
    .edge_o (start_edge)
  );

  conv_seq_fsm_edge_det u_next (
    .clk_i  (CLK100MHZ),
    .rst_i  (i_reset),
    .in_i   (bus.i_next),
    .edge_o (next_edge)
  );

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    nblk_d  = nblk_q;
    chblk_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_KLOAD;
          last_d  = bus.i_last_addr;
          nblk_d  = bus.i_nblk;
          blk_d   = '0;
          raddr_d = '0;
          waddr_d = '0;
        end
      end
      ST_KLOAD: begin
        if (raddr_q == KL_LAST) begin
          state_d = ST_RUN;
          raddr_d = '0;
          waddr_d = '0;
          cnt_d   = '0;
        end else begin
          raddr_d = raddr_q + A_ONE;
        end
      end
      ST_RUN: begin
        // write side starts once the first result is out of the pipe
        if (cnt_q == CNT_SAT) waddr_d = waddr_q + A_ONE;
        else                  cnt_d   = cnt_q + CNT_ONE;
        if (raddr_q == last_q) state_d = ST_FLUSH;
        else                   raddr_d = raddr_q + A_ONE;
      end
      ST_FLUSH: begin
        if (waddr_q == last_q) begin
          state_d = ST_WAIT;
          done_d  = (blk_q == nblk_q);
        end else begin
          waddr_d = waddr_q + A_ONE;
        end
      end
      ST_WAIT: begin
        if (blk_q == nblk_q) begin
          state_d = ST_IDLE;
        end else if (next_edge) begin
          state_d = ST_RUN;
          chblk_d = 1'b1;
          blk_d   = blk_q + B_ONE;
          raddr_d = '0;
          waddr_d = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_KLOAD) || (state_d == ST_RUN);
    ki_d    = (state_d == ST_IDLE) || (state_d == ST_KLOAD);
    sop_d   = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    eop_d   = (state_d == ST_IDLE) || (state_d == ST_WAIT);
  end

  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      raddr_q <= '0;
      waddr_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      nblk_q  <= '0;
      valid_q <= 1'b0;
      ki_q    <= 1'b1;
      sop_q   <= 1'b0;
      eop_q   <= 1'b1;
      chblk_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      nblk_q  <= nblk_d;
      valid_q <= valid_d;
      ki_q    <= ki_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      chblk_q <= chblk_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_RAddr = raddr_q;
  assign bus.o_WAddr = waddr_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ki    = ki_q;
  assign bus.o_sop   = sop_q;
  assign bus.o_eop   = eop_q;
  assign bus.o_chblk = chblk_q;
  assign bus.o_blk   = blk_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_conv_seq_fsm.sv
// Directed bench for conv_seq_fsm: every cycle of each frame is compared
// against hand-derived address/strobe values.
module tb_conv_seq_fsm;

  localparam int CL = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  conv_seq_fsm_if #(.NB_ADDRESS(10), .NB_BLK(4)) bus ();

  conv_seq_fsm dut (
    .CLK100MHZ (clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {2'b0, bus.o_RAddr, bus.o_WAddr, bus.o_blk, bus.o_valid,
            bus.o_ki, bus.o_sop, bus.o_eop, bus.o_chblk, bus.o_done};
  endfunction

  function automatic logic [31:0] pack(input int r, input int w,
      input bit v, input bit k, input bit s, input bit e,
      input bit c, input bit d, input int b);
    return {2'b0, 10'(r), 10'(w), 4'(b), v, k, s, e, c, d};
  endfunction

  // field order: raddr waddr valid ki sop eop chblk done blk
  task automatic step(input string tag, input int r, input int w,
      input bit v, input bit k, input bit s, input bit e,
      input bit c, input bit d, input int b);
    @(posedge clk);
    #1;
    check(tag, obs(), pack(r, w, v, k, s, e, c, d, b));
  endtask

  task automatic kload();
    for (int i = 0; i < 3; i++)
      step("kload", i, 0, 1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic run_block(input int last, input int blk, input bit chb,
                           input bit fin, input bit glitch);
    int fs;
    for (int k = 0; k <= last; k++) begin
      if (glitch && k == 1) begin
        bus.i_start = 1'b0;
        bus.i_next  = 1'b0;
      end
      if (glitch && k == 2) begin
        bus.i_start = 1'b1;
        bus.i_next  = 1'b1;
      end
      step("run", k, (k > CL) ? k - CL : 0, 1, 0, 1, 0,
           chb && (k == 0), 0, blk);
    end
    fs = (last >= CL) ? last - CL + 1 : 0;
    for (int w = fs; w <= last; w++)
      step("flush", last, w, 0, 0, 1, 0, 0, 0, blk);
    step("wait", last, last, 0, 0, 0, 1, 0, fin, blk);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_next = 1'b0;
    bus.i_last_addr = '0;
    bus.i_nblk = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", obs(), pack(0, 0, 0, 1, 0, 1, 0, 0, 0));
    rst = 1'b0;
    step("idle", 0, 0, 0, 1, 0, 1, 0, 0, 0);

    bus.i_next = 1'b1;
    step("idle_next", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step("idle_next", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    bus.i_next = 1'b0;

    // single block; inputs changed after start must not matter
    bus.i_last_addr = 10'd7;
    bus.i_nblk = 4'd0;
    bus.i_start = 1'b1;
    step("kload", 0, 0, 1, 1, 0, 0, 0, 0, 0);
    bus.i_start = 1'b0;
    bus.i_last_addr = 10'd3;
    bus.i_nblk = 4'd5;
    step("kload", 1, 0, 1, 1, 0, 0, 0, 0, 0);
    step("kload", 2, 0, 1, 1, 0, 0, 0, 0, 0);
    run_block(7, 0, 0, 1, 0);
    step("idle1", 7, 7, 0, 1, 0, 1, 0, 0, 0);

    // short block
    bus.i_last_addr = 10'd1;
    bus.i_nblk = 4'd0;
    bus.i_start = 1'b1;
    kload();
    bus.i_start = 1'b0;
    run_block(1, 0, 0, 1, 0);
    step("idle2", 1, 1, 0, 1, 0, 1, 0, 0, 0);

    // three blocks, with dropped edges in RUN and a held next
    bus.i_last_addr = 10'd4;
    bus.i_nblk = 4'd2;
    bus.i_start = 1'b1;
    kload();
    bus.i_start = 1'b0;
    run_block(4, 0, 0, 0, 0);
    step("wait_hold", 4, 4, 0, 0, 0, 1, 0, 0, 0);
    bus.i_next = 1'b1;
    run_block(4, 1, 1, 0, 1);
    step("wait_held", 4, 4, 0, 0, 0, 1, 0, 0, 1);
    bus.i_next = 1'b0;
    step("wait_low", 4, 4, 0, 0, 0, 1, 0, 0, 1);
    bus.i_next = 1'b1;
    run_block(4, 2, 1, 1, 0);
    step("idle3", 4, 4, 0, 1, 0, 1, 0, 0, 2);
    bus.i_start = 1'b0;
    bus.i_next = 1'b0;

    // maximum block: no address wrap
    bus.i_last_addr = 10'd1023;
    bus.i_nblk = 4'd0;
    step("idle4", 4, 4, 0, 1, 0, 1, 0, 0, 2);
    bus.i_start = 1'b1;
    kload();
    bus.i_start = 1'b0;
    run_block(1023, 0, 0, 1, 0);
    step("idle5", 1023, 1023, 0, 1, 0, 1, 0, 0, 0);

    // asynchronous reset in the middle of RUN
    bus.i_last_addr = 10'd7;
    bus.i_start = 1'b1;
    kload();
    bus.i_start = 1'b0;
    step("run_pre", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    step("run_pre", 1, 0, 1, 0, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", obs(), pack(0, 0, 0, 1, 0, 1, 0, 0, 0));
    step("rst_hold", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    rst = 1'b0;
    step("post_rst", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    bus.i_start = 1'b1;
    step("restart", 0, 0, 1, 1, 0, 0, 0, 0, 0);
    bus.i_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_seq_fsm.md
Name: conv_seq_fsm

Overview:
- Sequencer for the convolution datapath: N Conv lanes, the MCU column/block buffer, and N+2 line memories.
- Takes GPIO-level commands (start, next-block) from the micro side.
- Generates the read/write column addresses and the kernel/image select, valid, sop, eop and chblk strobes that sequence one frame.
- Replaces the ad-hoc address/strobe logic in the current test top.

Parameters:
NB_ADDRESS, 10, column address width
M_LEN, 3, kernel columns loaded per frame (kernel-load cycles)
CONV_LAT, 3, cycles from read address to corresponding Conv result at MCU write port
NB_BLK, 4, block counter width

Ports:
CLK100MHZ  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  GPIO level; rising edge starts a frame
i_next  in  1  GPIO level; rising edge advances to next block
i_last_addr  in  NB_ADDRESS  index of last column of a block; sampled on accepted start
i_nblk  in  NB_BLK  number of blocks minus 1; sampled on accepted start
o_RAddr  out  NB_ADDRESS  read column address to MCU
o_WAddr  out  NB_ADDRESS  write column address to MCU
o_valid  out  1  Conv i_valid
o_ki  out  1  Conv i_selecK_I (1 = kernel, 0 = image)
o_sop  out  1  block processing active
o_eop  out  1  block finished / idle; also drives LED
o_chblk  out  1  one-cycle pulse, block change
o_blk  out  NB_BLK  current block index
o_done  out  1  one-cycle pulse, frame complete

Behaviour:
- Interface: one clock, CLK100MHZ; reset i_reset is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - state IDLE
  - o_RAddr = 0, o_WAddr = 0, o_blk = 0
  - o_valid = 0, o_sop = 0, o_chblk = 0, o_done = 0
  - o_eop = 1, o_ki = 1
  - edge-detect registers cleared
- Edge detection: one register each on i_start and i_next; edge = in & ~prev.
  - Edges are recognised only in the states listed below and are otherwise dropped (not queued).
- IDLE:
  - o_eop = 1, o_ki = 1, o_valid = 0.
  - Start edge: latch i_last_addr and i_nblk, set blk = 0, RAddr = 0, go to KLOAD.
- KLOAD (exactly M_LEN cycles):
  - o_ki = 1, o_valid = 1, o_eop = 0.
  - o_RAddr = 0..M_LEN-1, one per cycle.
  - After the last cycle: RAddr = 0, WAddr = 0, run counter = 0, go to RUN.
- RUN:
  - o_ki = 0, o_valid = 1, o_sop = 1, o_eop = 0.
  - RAddr increments every cycle.
  - Run counter increments (saturating at CONV_LAT).
  - WAddr holds 0 while counter < CONV_LAT, then increments each cycle, so WAddr = RAddr - CONV_LAT.
  - The cycle with RAddr == last: go to FLUSH.
- FLUSH:
  - o_valid = 0; RAddr holds at last; o_sop stays 1.
  - WAddr keeps incrementing until WAddr == last, then go to WAIT.
  - If last < CONV_LAT, WAddr still counts 0..last.
- WAIT:
  - o_sop = 0, o_eop = 1.
  - If blk == nblk: pulse o_done for one cycle, go to IDLE (blk holds).
  - Else, on an i_next edge: o_chblk = 1 for one cycle, blk + 1, RAddr = WAddr = 0, go to RUN. No kernel reload.
- Simultaneous start and next edges: start is honoured only in IDLE; next only in WAIT.
- Async reset mid-operation: immediate return to reset values; no partial write strobes.
- Counters are unsigned and never wrap. last = 2^NB_ADDRESS - 1 is legal: RUN lasts 2^NB_ADDRESS cycles.

Decomposition:
- Shared package: state encoding (IDLE, KLOAD, RUN, FLUSH, WAIT) as localparams; the NB_ADDRESS, M_LEN and CONV_LAT defaults shared with Conv/MCU.
- One natural sub-module: edge_det (two instances, for start and next).

Test Plan:
- Reset: i_reset pulse mid-RUN → all outputs at reset values in the same cycle; o_eop = 1, o_ki = 1.
- Single block (last = 7, nblk = 0, start edge):
  - KLOAD 3 cycles with o_ki = 1, RAddr 0,1,2.
  - RUN 8 cycles, RAddr 0..7, o_valid = 1; WAddr 0,0,0,0,1,2,3,4.
  - FLUSH 3 cycles, WAddr 5,6,7, o_valid = 0.
  - WAIT, o_done one pulse, back in IDLE.
- Two blocks (nblk = 1): after block 0 WAIT, next edge → o_chblk one pulse, o_blk = 1, RUN restarts at RAddr 0 with o_ki = 0 (no KLOAD). After block 1, o_done pulses.
- Dropped edges: start edge during RUN and next edge during IDLE are ignored; next held high is one edge only; a second next while in RUN is ignored.
- Short block (last = 1): RUN 2 cycles (RAddr 0,1), FLUSH emits WAddr 0,1, then WAIT.
- Max block (last = 1023): RAddr reaches 1023 without wrap; WAddr ends at 1023; total RUN + FLUSH = 1027 cycles.
